// File: rtl/suma_productos_secuencial.sv
// suma_productos_secuencial
// Streaming unsigned sum-of-products: accepts TERMS (a, b) pairs over a
// valid/ready input, accumulates a*b at full precision, and presents the
// total on a valid/ready output. Reusable MAC / dot-product building block.
//
// state  | meaning
// -------+-------------------------------------------------------------
// ACUM   | accepting operand pairs, in_ready=1, out_valid=0
// SALIDA | result held on out_sum, out_valid=1, in_ready=0 (one bubble)
module suma_productos_secuencial #(
    parameter int WIDTH = 8,
    parameter int TERMS = 4,
    localparam int ACC_W = 2*WIDTH + $clog2(TERMS),
    localparam int CNT_W = $clog2(TERMS) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] term_count
);

    typedef enum logic [0:0] {
        ACUM   = 1'b0,
        SALIDA = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TERMS - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_count;
    logic [ACC_W-1:0]   r_out_sum;

    logic [2*WIDTH-1:0] w_prod;
    logic [ACC_W-1:0]   w_sum;
    logic               w_accept;
    logic               w_last;

    // Single combinational multiply stage, zero-extended into the accumulator.
    // The extra $clog2(TERMS) bits make overflow impossible, so no wrap logic.
    assign w_prod   = {{WIDTH{1'b0}}, in_a} * {{WIDTH{1'b0}}, in_b};
    assign w_sum    = r_acc + {{(ACC_W-2*WIDTH){1'b0}}, w_prod};

    // Handshake outputs decode the registered state only, so no combinational
    // path runs from in_valid or out_ready to in_ready/out_valid.
    assign in_ready  = (r_state == ACUM);
    assign out_valid = (r_state == SALIDA);

    // A beat coinciding with clear is dropped, not accumulated.
    assign w_accept = in_valid && in_ready && !clear;
    assign w_last   = w_accept && (r_count == LAST_IDX);

    assign out_sum    = r_out_sum;
    assign term_count = r_count;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ACUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: clear wins over handshakes; output leaves on out_ready.
    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = ACUM;
        end else begin
            unique case (r_state)
                ACUM: begin
                    if (w_last) begin
                        w_state_next = SALIDA;
                    end
                end
                SALIDA: begin
                    if (out_ready) begin
                        w_state_next = ACUM;
                    end
                end
                default: w_state_next = ACUM;
            endcase
        end
    end

    // Accumulator and term counter: restart from zero on the final beat or abort.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_count <= '0;
        end else if (clear) begin
            r_acc   <= '0;
            r_count <= '0;
        end else if (w_last) begin
            r_acc   <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_acc   <= w_sum;
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Result register: loaded only on a completed sum; clear leaves it untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_sum <= '0;
        end else if (w_last) begin
            r_out_sum <= w_sum;
        end
    end

endmodule

// File: tb/tb_suma_productos_secuencial.sv
module tb_suma_productos_secuencial;

    localparam int W    = 8;
    localparam int ACCW = 18;

    logic            clk = 1'b0;
    logic            rst_n, clear;
    logic            in_valid, out_ready;
    logic [W-1:0]    in_a, in_b;
    logic            in_ready, out_valid;
    logic [ACCW-1:0] out_sum;
    logic [2:0]      term_count;

    logic            v3, ordy3;
    logic [W-1:0]    a3, b3;
    logic            rdy3, ov3;
    logic [ACCW-1:0] sum3;
    logic [2:0]      tc3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    suma_productos_secuencial #(.WIDTH(8), .TERMS(4)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .term_count(term_count)
    );

    suma_productos_secuencial #(.WIDTH(8), .TERMS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(v3), .in_ready(rdy3), .in_a(a3), .in_b(b3),
        .out_valid(ov3), .out_ready(ordy3),
        .out_sum(sum3), .term_count(tc3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // one clock edge, then settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0;
        v3 = 1'b0; a3 = '0; b3 = '0; ordy3 = 1'b1;
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_sum", 32'(out_sum), 0);
        chk("rst_term_count", 32'(term_count), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        rst_n = 1'b1;

        // basic sum: 1*2+3*4+5*6+7*8 = 100
        beat(8'd1, 8'd2); chk("basic_tc1", 32'(term_count), 1);
        beat(8'd3, 8'd4); chk("basic_tc2", 32'(term_count), 2);
        beat(8'd5, 8'd6); chk("basic_tc3", 32'(term_count), 3);
        chk("basic_no_valid_early", 32'(out_valid), 0);
        beat(8'd7, 8'd8);
        chk("basic_out_valid", 32'(out_valid), 1);
        chk("basic_out_sum", 32'(out_sum), 100);
        chk("basic_in_ready_low", 32'(in_ready), 0);
        chk("basic_tc_wrap", 32'(term_count), 0);
        in_valid = 1'b0;
        tick();
        chk("basic_valid_one_cycle", 32'(out_valid), 0);
        chk("basic_in_ready_back", 32'(in_ready), 1);
        chk("basic_sum_kept", 32'(out_sum), 100);

        // maximum operands: 4*255*255 = 260100
        for (int i = 0; i < 4; i++) beat(8'd255, 8'd255);
        chk("max_out_valid", 32'(out_valid), 1);
        chk("max_out_sum", 32'(out_sum), 260100);

        // output backpressure with producer holding (2,3)
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 8'd2; in_b = 8'd3;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_out_sum", 32'(out_sum), 260100);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_tc", 32'(term_count), 0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(out_valid), 0);
        chk("bp_release_tc", 32'(term_count), 0);
        tick();
        chk("bp_first_accept_tc", 32'(term_count), 1);
        tick(); tick(); tick();
        chk("bp_next_valid", 32'(out_valid), 1);
        chk("bp_next_sum", 32'(out_sum), 24);
        in_valid = 1'b0;
        tick();

        // clear mid-sum drops the coincident beat
        beat(8'd10, 8'd10); beat(8'd10, 8'd10);
        chk("clr_tc_before", 32'(term_count), 2);
        clear = 1'b1; in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9;
        tick();
        clear = 1'b0;
        chk("clr_tc", 32'(term_count), 0);
        chk("clr_out_valid", 32'(out_valid), 0);
        chk("clr_in_ready", 32'(in_ready), 1);
        chk("clr_sum_kept", 32'(out_sum), 24);
        for (int i = 0; i < 4; i++) beat(8'd1, 8'd1);
        chk("clr_result_valid", 32'(out_valid), 1);
        chk("clr_result_sum", 32'(out_sum), 4);

        // clear during SALIDA: no result left pending, out_sum kept
        in_valid = 1'b0; out_ready = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0; out_ready = 1'b1;
        chk("clr_salida_valid", 32'(out_valid), 0);
        chk("clr_salida_sum", 32'(out_sum), 4);

        // reset during SALIDA
        for (int i = 0; i < 4; i++) beat(8'd2, 8'd2);
        chk("rst_salida_pre_valid", 32'(out_valid), 1);
        in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1; out_ready = 1'b1;
        chk("rst_salida_valid", 32'(out_valid), 0);
        chk("rst_salida_sum", 32'(out_sum), 0);
        chk("rst_salida_tc", 32'(term_count), 0);
        chk("rst_salida_in_ready", 32'(in_ready), 1);

        // TERMS=3 instance, irregular in_valid: 4*5+6*7+1*1 = 63
        v3 = 1'b1; a3 = 8'd4; b3 = 8'd5;
        tick();
        chk("t3_tc1", 32'(tc3), 1);
        v3 = 1'b0;
        for (int i = 0; i < int'($urandom_range(1, 4)); i++) begin
            a3 = 8'($urandom); b3 = 8'($urandom);
            tick();
        end
        chk("t3_tc1_idle", 32'(tc3), 1);
        v3 = 1'b1; a3 = 8'd6; b3 = 8'd7;
        tick();
        chk("t3_tc2", 32'(tc3), 2);
        v3 = 1'b0;
        for (int i = 0; i < int'($urandom_range(1, 4)); i++) begin
            a3 = 8'($urandom); b3 = 8'($urandom);
            tick();
        end
        chk("t3_no_valid_early", 32'(ov3), 0);
        v3 = 1'b1; a3 = 8'd1; b3 = 8'd1;
        tick();
        v3 = 1'b0;
        chk("t3_valid", 32'(ov3), 1);
        chk("t3_sum", 32'(sum3), 63);
        chk("t3_tc0", 32'(tc3), 0);
        tick();
        chk("t3_valid_drop", 32'(ov3), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/suma_productos_secuencial.md
# suma_productos_secuencial

Streaming sum-of-products unit that generalises the 4-input two-term AND/OR sum-of-products to arithmetic.
- Accepts TERMS operand pairs of WIDTH bits, one pair per accepted beat.
- Accumulates their unsigned products and presents the total on a valid/ready output port.
- Serves as the reusable dot-product/MAC building block for filter and correlator datapaths.

## Interface
- WIDTH, 8, operand width in bits (≥1)
- TERMS, 4, number of products per sum (≥2)
- ACC_W, 2*WIDTH+$clog2(TERMS), result width (derived localparam, not overridable)
- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- clear  input  1  synchronous abort: discard partial sum and any pending result
- in_valid  input  1  operand pair present
- in_ready  output  1  block can accept a pair this cycle
- in_a  input  WIDTH  multiplicand, unsigned
- in_b  input  WIDTH  multiplier, unsigned
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  ACC_W  sum of TERMS products
- term_count  output  $clog2(TERMS)+1  pairs accepted in the current sum

## Operation
- Two states:
  - ACUM: in_ready=1, out_valid=0.
  - SALIDA: in_ready=0, out_valid=1.
- Accept in ACUM when in_valid && in_ready:
  - acc <= acc + in_a*in_b, zero-extended to ACC_W.
  - term_count increments.
- Accept that brings term_count to TERMS:
  - out_sum <= acc + in_a*in_b.
  - acc <= 0, term_count <= 0, state -> SALIDA.
- SALIDA:
  - out_sum, out_valid held stable until out_valid && out_ready.
  - Then state -> ACUM next cycle; out_sum keeps its last value.
- in_valid while in_ready=0 is ignored; the pair is not consumed.
- Arithmetic: unsigned, full precision.
  - ACC_W guarantees no overflow at TERMS × (2^WIDTH−1)^2.
  - No saturation or wrap logic.
- clear=1, any state:
  - Next cycle: state ACUM, acc=0, term_count=0, out_valid=0.
  - out_sum is not cleared.
  - Beats in the same cycle as clear are dropped and not accumulated.
- Priority: rst_n low > clear > handshakes.
- in_a and in_b need not be stable outside accepted beats.

## Timing
- Reset (rst_n sampled low at rising edge):
  - state ACUM, acc=0, term_count=0, out_valid=0, out_sum=0.
  - in_ready=1 from the first cycle after reset release.
- in_ready is a registered state decode (no combinational path from in_valid or out_ready).
- out_valid rises the cycle after the TERMS-th accepted beat (latency 1).
- Throughput: TERMS input beats + 1 output cycle per result minimum.
  - One bubble per result: in_ready=0 during the SALIDA cycle(s).
- Back-to-back input with in_valid held high:
  - Accepted every cycle in ACUM.
  - The beat presented during SALIDA is held by the producer and accepted the first ACUM cycle.
- Reset or clear mid-sum or mid-SALIDA loses all partial data. No result is emitted for the aborted sum.
- Multiplier is a single combinational stage feeding the accumulator register. Retiming is allowed only if the latency and handshake above are unchanged.

## Test plan
- Basic sum, WIDTH=8, TERMS=4:
  - Stimulus: pairs (1,2),(3,4),(5,6),(7,8) on consecutive cycles, out_ready=1.
  - Response: out_valid one cycle after 4th beat, out_sum=100, one cycle high, in_ready=0 that cycle only.
- Maximum operands:
  - Stimulus: 4×(255,255).
  - Response: out_sum=260100 (18-bit, no overflow); next sum starts from 0.
- Output backpressure:
  - Stimulus: out_ready=0 for 5 cycles after result, in_valid held high with (2,3).
  - Response: out_valid and out_sum stable, in_ready=0, no pairs consumed; after out_ready=1, next sum of 4×(2,3)=24.
- Clear mid-sum:
  - Stimulus: accept (10,10),(10,10), assert clear with in_valid=1 (9,9), then feed 4×(1,1).
  - Response: (9,9) dropped, term_count=0 after clear, result out_sum=4.
- Reset mid-SALIDA:
  - Stimulus: rst_n low one cycle while out_valid=1.
  - Response: next cycle out_valid=0, out_sum=0, term_count=0, in_ready=1.
- Irregular in_valid, TERMS=3 build:
  - Stimulus: pairs (4,5),(6,7),(1,1) with random idle gaps.
  - Response: out_sum=63, term_count steps 1,2 then 0 on completion.
